seq_detect_prog: RTL
====================

Name: seq_detect_prog

Overview:
Programmable serial bit-pattern detector. It is the parametrised successor to the fixed 5-state Moore "1101" detector.
- Accepts one qualified input bit per cycle.
- Compares the most recent N bits against a runtime-loaded pattern of length 1..MAX_LEN.
- Supports overlapping and non-overlapping modes.
- Produces a registered Moore-style match pulse and a saturating match counter.
- Sits between the tile input pins and the output/status pins.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (≥2).
CNT_W, 8, width of the match counter.
LEN_W, $clog2(MAX_LEN+1), width of pattern-length and fill fields (derived; do not override).

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
din  in  1  serial data bit
din_valid  in  1  din is sampled this cycle when high
cfg_load  in  1  one-cycle strobe: latch pat_in/len_in/overlap_in
pat_in  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
len_in  in  LEN_W  pattern length
overlap_in  in  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  in  1  clears match_count
match  out  1  registered one-cycle pulse per detected pattern
match_count  out  CNT_W  saturating count of matches
fill  out  LEN_W  valid history bits held, saturates at active length
active_len  out  LEN_W  currently latched effective length

Behaviour:
- Reset (rst_n=0 at a clk edge) clears the following to 0: history, fill, match, match_count, pattern, active_len and overlap. Reset mid-stream discards all history. With length 0 the block never matches until configured.
- Config load (cfg_load=1):
  - Latches pattern and overlap mode.
  - active_len = min(len_in, MAX_LEN). len_in=0 latches 0, which disables detection.
  - Clears history and fill to 0. match_count is unaffected.
  - If din_valid=1 in the same cycle, cfg_load wins and the bit is discarded. match is 0 in the cycle after a load.
- Shift: when din_valid=1 and cfg_load=0:
  - hist <= {hist[MAX_LEN-2:0], din}, so hist[0] is the newest bit.
  - fill <= min(fill+1, active_len).
  - When din_valid=0, history and fill hold and match is 0 next cycle.
- Match condition, evaluated combinationally on the post-shift view (hist shifted with the current din):
  - Requires din_valid=1, active_len≠0, and fill+1 ≥ active_len.
  - Requires shifted_hist[k]==pat[k] for all k<active_len. Bits at k≥active_len are ignored.
- Match response:
  - match registers the condition, giving 1-cycle latency after the accepting edge.
  - match_count increments and saturates at 2^CNT_W-1; it never wraps.
  - Overlapping mode: history continues normally.
  - Non-overlapping mode: on a match, fill <= 0 and history is cleared, so the next match needs active_len fresh bits.
- Counter clear:
  - cnt_clr=1 sets match_count to 0.
  - cnt_clr takes priority over a simultaneous increment (result 0).
  - match still pulses in that case.
- Structure:
  - The FSM is two states, IDLE (active_len==0) and RUN.
  - The IDLE→RUN transition happens only via a cfg_load with len≥1.
  - The RUN→IDLE transition happens via a cfg_load with len=0, or via reset.
- All outputs are registered. There is no clock-gated or combinational-from-clk output.

Optional Feature:
STICKY_IRQ_EN
- Defined:
  - Adds output irq (1 bit) and input irq_clr (1 bit).
  - irq is set on any match and holds until irq_clr=1.
  - Set wins over a simultaneous clear.
  - Reset clears irq.
- Undefined: irq and irq_clr ports do not exist and no sticky logic is generated.

Test Plan:
1. Reset: drive rst_n=0 for 2 cycles with din_valid toggling → match=0, match_count=0, fill=0, active_len=0; no match on any stream until configured.
2. Overlap detect: load pat=0b1101, len=4, overlap=1; feed 1,1,0,1,1,0,1 → match pulses one cycle after the 4th and 7th bits; match_count=2.
3. Non-overlap: same pattern with overlap=0 and the same stream → a single match after the 4th bit; fill returns to 0; match_count=1.
4. Qualification and reload:
   - Insert din_valid=0 gaps inside 1101 → still exactly one match; gaps have no effect.
   - Assert cfg_load together with din_valid mid-pattern → bit discarded, fill=0, no spurious match.
5. Boundaries:
   - len_in=0 → never match.
   - len_in=MAX_LEN+3 → active_len=MAX_LEN.
   - len=1, pat=1 with a stream of all ones → match every valid cycle.
   - match_count saturates at 255 with CNT_W=8 after 300 matches.
   - cnt_clr together with a match → count=0.
6. STICKY_IRQ_EN: match then wait 10 cycles → irq remains 1; irq_clr → 0; irq_clr coincident with a match → irq stays 1.

Source files
------------

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial bit-pattern detector with saturating match counter
// Optional sticky interrupt output enabled by defining STICKY_IRQ_EN.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap_in,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill,
  output logic [LEN_W-1:0]   active_len
`ifdef STICKY_IRQ_EN
  ,
  input  logic               irq_clr,
  output logic               irq
`endif
);

  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       RUN     = 1'b1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]         state;
  logic [MAX_LEN-1:0] pattern;
  logic [MAX_LEN-1:0] pat_mask;
  logic [MAX_LEN-1:0] load_mask;
  logic [MAX_LEN-1:0] shifted;
  // The oldest history bit is shifted out before it can ever be compared, so only MAX_LEN-1 bits are stored.
  logic [MAX_LEN-2:0] hist;
  logic               overlap;
  logic [LEN_W-1:0]   len_eff;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W:0]     fill_inc;
  logic               match_cond;

  always_comb begin
    len_eff = (len_in > LEN_MAX) ? LEN_MAX : len_in;
    load_mask = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      load_mask[k] = (k < int'(len_eff));
    end
  end

  always_comb begin
    shifted    = {hist, din};
    fill_inc   = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    fill_next  = (fill_inc > {1'b0, active_len}) ? active_len : fill_inc[LEN_W-1:0];
    match_cond = (state == RUN) && din_valid && !cfg_load &&
                 (fill_inc >= {1'b0, active_len}) &&
                 (((shifted ^ pattern) & pat_mask) == '0);
  end

  // IDLE <-> RUN only moves on a config load (or reset); IDLE is exactly active_len == 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pattern    <= '0;
      pat_mask   <= '0;
      active_len <= '0;
      overlap    <= 1'b0;
    end else if (cfg_load) begin
      pattern    <= pat_in;
      pat_mask   <= load_mask;
      active_len <= len_eff;
      overlap    <= overlap_in;
      state      <= (len_eff != '0) ? RUN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cfg_load) begin
      hist <= '0;
      fill <= '0;
    end else if (din_valid) begin
      if (match_cond && !overlap) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= shifted[MAX_LEN-2:0];
        fill <= fill_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= match_cond;
      if (cnt_clr) begin
        match_count <= '0;
      end else if (match_cond && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_ONE;
      end
    end
  end

`ifdef STICKY_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (match_cond) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
